rv_bypass_ctrl: RTL and testbench

//  Scoreboard/controller for the operand bypass muxes. Tracks the destination register of every instruction
//  in the alu2, memory, write and wr_back stages and generates the ctrl_rs_bp_t select for rs1/rs2 of the

---
 rtl/rv_bypass_ctrl.sv | 96 +++++++++
 tb/tb_rv_bypass_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_bypass_ctrl.sv
// Operand bypass scoreboard for the decode stage.
// Tracks the destination of the instruction held in each of alu2, memory, write
// and wr_back. Builds a one-hot bypass select for rs1/rs2, where the youngest
// producer wins, and stalls decode when a load result is not ready yet.
module rv_bypass_ctrl #(
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_W            = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_dec_valid,
  input  logic [4:0]       i_dec_rs1,
  input  logic [4:0]       i_dec_rs2,
  input  logic             i_dec_rs1_use,
  input  logic             i_dec_rs2_use,
  input  logic [4:0]       i_dec_rd,
  input  logic             i_dec_rd_we,
  input  logic             i_dec_load,
  input  logic             i_hold,
  input  logic             i_flush,
  output logic [3:0]       o_rs1_bp,
  output logic [3:0]       o_rs2_bp,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Entry index 0 is alu2 (youngest) and index 3 is wr_back (oldest).
  logic [3:0] e_vld;
  logic [3:0] e_load;
  logic [4:0] e_rd [4];

  logic [3:0] match1;
  logic [3:0] match2;
  logic       hazard;
  logic       capture;

  // The youngest matching stage wins. The select bit order is {alu2,memory,write,wr_back}.
  function automatic logic [3:0] youngest_sel(input logic [3:0] m);
    if (m[0])      return 4'b1000;
    else if (m[1]) return 4'b0100;
    else if (m[2]) return 4'b0010;
    else if (m[3]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  // Saturating increment. The counter holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Matches the decode operands against each in-flight destination. x0 is never forwarded.
  always_comb begin
    match1 = '0;
    match2 = '0;
    hazard = 1'b0;
    for (int k = 0; k < 4; k++) begin
      match1[k] = i_dec_valid & i_dec_rs1_use & e_vld[k] &
                  (e_rd[k] == i_dec_rs1) & (i_dec_rs1 != 5'd0);
      match2[k] = i_dec_valid & i_dec_rs2_use & e_vld[k] &
                  (e_rd[k] == i_dec_rs2) & (i_dec_rs2 != 5'd0);
      if ((k < LOAD_READY_STAGE) && e_load[k] && (match1[k] || match2[k]))
        hazard = 1'b1;
    end
  end

  assign o_rs1_bp = youngest_sel(match1);
  assign o_rs2_bp = youngest_sel(match2);
  assign o_stall  = hazard & ~i_flush;
  assign capture  = i_dec_valid & i_dec_rd_we & (i_dec_rd != 5'd0) & ~o_stall & ~i_flush;

  // Shifts the scoreboard one stage unless frozen. A stall inserts a bubble and a flush kills alu2.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      e_vld       <= '0;
      e_load      <= '0;
      for (int k = 0; k < 4; k++) e_rd[k] <= '0;
      o_stall_cnt <= '0;
    end else if (!i_hold) begin
      e_vld[3]  <= e_vld[2];
      e_vld[2]  <= e_vld[1];
      e_vld[1]  <= e_vld[0] & ~i_flush;
      e_vld[0]  <= capture;
      e_load[3] <= e_load[2];
      e_load[2] <= e_load[1];
      e_load[1] <= e_load[0];
      e_load[0] <= i_dec_load;
      e_rd[3]   <= e_rd[2];
      e_rd[2]   <= e_rd[1];
      e_rd[1]   <= e_rd[0];
      e_rd[0]   <= i_dec_rd;
      if (o_stall) o_stall_cnt <= sat_inc(o_stall_cnt);
    end
  end

endmodule

// File: tb/tb_rv_bypass_ctrl.sv
// Self-checking bench for rv_bypass_ctrl. The reference model keeps a queue of
// in-flight writers: the youngest is at the front, and stall and forwarding
// decisions are derived from it directly. Two DUT instances (CNT_W=16 and 4)
// share the stimulus so that counter saturation is also covered.
module tb_rv_bypass_ctrl;
  localparam int LRS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dv, u1, u2, we, ld, hold, flush;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] bp1a, bp2a, bp1b, bp2b;
  logic       stalla, stallb;
  logic [15:0] cnta;
  logic [3:0]  cntb;

  rv_bypass_ctrl #(.LOAD_READY_STAGE(LRS), .CNT_W(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_dec_valid(dv), .i_dec_rs1(rs1), .i_dec_rs2(rs2),
    .i_dec_rs1_use(u1), .i_dec_rs2_use(u2), .i_dec_rd(rd), .i_dec_rd_we(we),
    .i_dec_load(ld), .i_hold(hold), .i_flush(flush),
    .o_rs1_bp(bp1a), .o_rs2_bp(bp2a), .o_stall(stalla), .o_stall_cnt(cnta));

  rv_bypass_ctrl #(.LOAD_READY_STAGE(LRS), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_dec_valid(dv), .i_dec_rs1(rs1), .i_dec_rs2(rs2),
    .i_dec_rs1_use(u1), .i_dec_rs2_use(u2), .i_dec_rd(rd), .i_dec_rd_we(we),
    .i_dec_load(ld), .i_hold(hold), .i_flush(flush),
    .o_rs1_bp(bp1b), .o_rs2_bp(bp2b), .o_stall(stallb), .o_stall_cnt(cntb));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each slot records one instruction in flight. Index 0 is the youngest.
  typedef struct packed { bit v; bit [4:0] r; bit l; } slot_t;
  slot_t       q[$];
  int unsigned mc16, mc4;

  function automatic logic [3:0] exp_sel(input logic [4:0] rs, input logic use_);
    for (int k = 0; k < 4; k++)
      if (dv && use_ && rs != 5'd0 && q[k].v && q[k].r == rs) return 4'b1000 >> k;
    return 4'b0000;
  endfunction

  function automatic logic exp_stall();
    logic h = 1'b0;
    for (int k = 0; k < LRS; k++)
      if (q[k].v && q[k].l && dv &&
          ((u1 && rs1 != 5'd0 && q[k].r == rs1) || (u2 && rs2 != 5'd0 && q[k].r == rs2)))
        h = 1'b1;
    return h && !flush;
  endfunction

  task automatic model_clear();
    q = {};
    repeat (4) q.push_back('0);
    mc16 = 0;
    mc4  = 0;
  endtask

  // Runs one clock cycle. Inputs are already driven at the negedge; checks fire 1 time unit later.
  task automatic cyc(input bit chk);
    logic [3:0] e1, e2;
    logic es;
    slot_t n;
    #1;
    e1 = exp_sel(rs1, u1);
    e2 = exp_sel(rs2, u2);
    es = exp_stall();
    if (chk) begin
      check("rs1_bp16", {28'd0, bp1a}, {28'd0, e1});
      check("rs2_bp16", {28'd0, bp2a}, {28'd0, e2});
      check("stall16", {31'd0, stalla}, {31'd0, es});
      check("cnt16", {16'd0, cnta}, mc16);
      check("rs1_bp4", {28'd0, bp1b}, {28'd0, e1});
      check("rs2_bp4", {28'd0, bp2b}, {28'd0, e2});
      check("stall4", {31'd0, stallb}, {31'd0, es});
      check("cnt4", {28'd0, cntb}, mc4);
    end
    @(posedge clk);
    if (rst) model_clear();
    else if (!hold) begin
      n.v = dv && we && rd != 5'd0 && !es && !flush;
      n.r = rd;
      n.l = ld;
      if (flush) q[0].v = 1'b0;
      q.push_front(n);
      void'(q.pop_back());
      if (es) begin
        if (mc16 < 65535) mc16++;
        if (mc4 < 15) mc4++;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; dv = 0; u1 = 0; u2 = 0; we = 0; ld = 0; hold = 0; flush = 0;
    rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic instr(input logic [4:0] d, input logic w, input logic l,
                       input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
    quiet();
    dv = 1; rd = d; we = w; ld = l; rs1 = a; u1 = ua; rs2 = b; u2 = ub;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    cyc(1);
    cyc(1);
    quiet();
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    // Reset with random inputs, two cycles. The first cycle is unchecked because the state is still unknown.
    rst = 1; dv = 1'($urandom); u1 = 1'($urandom); u2 = 1'($urandom);
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    we = 1'($urandom); ld = 1'($urandom); hold = 1'($urandom); flush = 1'($urandom);
    cyc(0);
    cyc(1);
    quiet();
    #1;
    check("rst_rs1", {28'd0, bp1a}, 32'd0);
    check("rst_rs2", {28'd0, bp2a}, 32'd0);
    check("rst_stall", {31'd0, stalla}, 32'd0);
    check("rst_cnt", {16'd0, cnta}, 32'd0);
    cyc(1);

    // ALU chain with 0..4 gaps between the producer and the consumer.
    for (int g = 0; g <= 4; g++) begin
      logic [3:0] want;
      want = (g == 4) ? 4'b0000 : (4'b1000 >> g);
      do_reset();
      instr(5, 1, 0, 0, 0, 0, 0);
      cyc(1);
      quiet();
      repeat (g) cyc(1);
      instr(6, 1, 0, 5, 1, 5, 1);
      #1;
      check($sformatf("chain_rs1_g%0d", g), {28'd0, bp1a}, {28'd0, want});
      check($sformatf("chain_rs2_g%0d", g), {28'd0, bp2a}, {28'd0, want});
      cyc(1);
    end

    // Load-use: lw x7, then add x8,x7,x1.
    do_reset();
    instr(7, 1, 1, 0, 0, 0, 0);
    cyc(1);
    instr(8, 1, 0, 7, 1, 1, 1);
    #1 check("lu_stall1", {31'd0, stalla}, 32'd1);
    cyc(1);
    #1 check("lu_stall2", {31'd0, stalla}, 32'd1);
    cyc(1);
    #1 check("lu_stall3", {31'd0, stalla}, 32'd0);
    check("lu_rs1_write", {28'd0, bp1a}, 32'b0010);
    check("lu_rs2_rf", {28'd0, bp2a}, 32'd0);
    cyc(1);
    quiet();
    #1 check("lu_cnt", {16'd0, cnta}, 32'd2);
    cyc(1);

    // Priority between two writers of x9, and a read of x0 while an x0 write is in flight.
    do_reset();
    instr(9, 1, 0, 0, 0, 0, 0);
    cyc(1);
    quiet();
    cyc(1);
    cyc(1);
    instr(9, 1, 0, 0, 0, 0, 0);
    cyc(1);
    instr(1, 1, 0, 9, 1, 0, 0);
    #1 check("prio_alu2", {28'd0, bp1a}, 32'b1000);
    cyc(1);
    instr(0, 1, 0, 0, 0, 0, 0);
    cyc(1);
    instr(2, 1, 0, 0, 1, 0, 1);
    #1 check("x0_rs1", {28'd0, bp1a}, 32'd0);
    check("x0_rs2", {28'd0, bp2a}, 32'd0);
    cyc(1);

    // Hold for three cycles during a load-use stall.
    do_reset();
    instr(7, 1, 1, 0, 0, 0, 0);
    cyc(1);
    instr(8, 1, 0, 7, 1, 0, 0);
    hold = 1;
    repeat (3) cyc(1);
    #1 check("hold_cnt", {16'd0, cnta}, 32'd0);
    check("hold_bp", {28'd0, bp1a}, 32'b1000);
    hold = 0;
    repeat (3) cyc(1);
    quiet();
    #1 check("hold_cnt_after", {16'd0, cnta}, 32'd2);
    cyc(1);

    // Flush while x10 sits in alu2.
    do_reset();
    instr(10, 1, 0, 0, 0, 0, 0);
    cyc(1);
    instr(11, 1, 1, 0, 0, 0, 0);
    flush = 1;
    cyc(1);
    instr(12, 1, 0, 10, 1, 11, 1);
    #1 check("flush_rs1", {28'd0, bp1a}, 32'd0);
    check("flush_rs2", {28'd0, bp2a}, 32'd0);
    check("flush_stall", {31'd0, stalla}, 32'd0);
    cyc(1);

    // Saturation: 30 cycles of a self-dependent load produce 20 stall cycles.
    do_reset();
    instr(7, 1, 1, 7, 1, 0, 0);
    repeat (30) cyc(1);
    quiet();
    #1 check("sat_cnt4", {28'd0, cntb}, 32'hF);
    check("sat_cnt16", {16'd0, cnta}, 32'd20);
    cyc(1);

    // Random traffic over a small register set, so that matches occur often.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      hold  = ($urandom_range(0, 99) < 10);
      flush = ($urandom_range(0, 99) < 10);
      dv    = ($urandom_range(0, 99) < 85);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      u1    = 1'($urandom);
      u2    = 1'($urandom);
      we    = ($urandom_range(0, 99) < 80);
      ld    = ($urandom_range(0, 99) < 35);
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
